// File: rtl/rv_muldiv_pkg.sv
// Shared types and two's-complement helpers for the iterative RV32M multiply/divide unit.
package rv_muldiv_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   function automatic logic [XLEN_DEF-1:0] abs_val(input logic [XLEN_DEF-1:0] v,
                                                    input logic is_signed);
      return (is_signed && v[XLEN_DEF-1]) ? -v : v;
   endfunction

   function automatic logic [XLEN_DEF-1:0] neg_if(input logic [XLEN_DEF-1:0] v,
                                                  input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*XLEN_DEF-1:0] neg_if_wide(input logic [2*XLEN_DEF-1:0] v,
                                                         input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M mul/div beside the E-stage ALU: result ITERS+1 cycles after accept (1 for div-by-zero/overflow).
// Stalls F/D/E while accepting or iterating; flush aborts in any state with no result.
module execute_muldiv_unit
   import rv_muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int ITERS = XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] src_a_i,
   input  logic [XLEN-1:0] src_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic [XLEN-1:0] result_o,
   output logic            valid_o
);

   localparam int          CW   = 6;
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   muldiv_state_e   state, state_nxt;
   muldiv_op_e      op_q, op_in;
   logic [CW-1:0]   cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0] dvsr;
   logic            neg_q;
   logic            special_q;
   logic [XLEN-1:0] spec_res_q;

   logic            accept;
   logic            is_div, a_signed, b_signed, a_neg, b_neg;
   logic            div_zero, div_ovf, special_in, neg_in;
   logic [XLEN-1:0] a_mag, b_mag, spec_res_in;

   // Decode and special-case detection on the raw forwarded operands
   always_comb begin
      op_in       = muldiv_op_e'(funct3_i);
      is_div      = funct3_i[2];
      a_signed    = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed    = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      a_neg       = a_signed & src_a_i[XLEN-1];
      b_neg       = b_signed & src_b_i[XLEN-1];
      a_mag       = abs_val(src_a_i, a_signed);
      b_mag       = abs_val(src_b_i, b_signed);
      div_zero    = is_div && (src_b_i == '0);
      div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                    (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
      special_in  = div_zero | div_ovf;
      neg_in      = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
      spec_res_in = '0;
      if (div_zero)
         spec_res_in = funct3_i[1] ? src_a_i : '1;
      else if (div_ovf)
         spec_res_in = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   assign accept = (state == IDLE) && start_i && !flush_i;

   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] mul_nxt;
   logic [XLEN:0]     rem_trial;
   logic              fits;
   logic [XLEN-1:0]   rem_sub;
   logic [2*XLEN-1:0] div_nxt;

   // One shift-add step or one restoring-divide step on the shared accumulator
   always_comb begin
      add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? dvsr : '0)};
      mul_nxt   = {add_sum, acc[XLEN-1:1]};
      rem_trial = acc[2*XLEN-1:XLEN-1];
      fits      = rem_trial >= {1'b0, dvsr};
      rem_sub   = rem_trial[XLEN-1:0] - dvsr;
      div_nxt   = fits ? {rem_sub, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= OP_MUL;
         cnt        <= '0;
         acc        <= '0;
         dvsr       <= '0;
         neg_q      <= 1'b0;
         special_q  <= 1'b0;
         spec_res_q <= '0;
      end else if (accept) begin
         op_q       <= op_in;
         cnt        <= '0;
         acc        <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
         dvsr       <= is_div ? b_mag : a_mag;
         neg_q      <= neg_in;
         special_q  <= special_in;
         spec_res_q <= spec_res_in;
      end else if (state == BUSY && !flush_i) begin
         acc <= op_q[2] ? div_nxt : mul_nxt;
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special_in ? DONE : BUSY;
         BUSY:    if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush_i)
         state_nxt = IDLE;
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   res_sel;

   always_comb begin
      prod = neg_if_wide(acc, neg_q);
      case (op_q)
         OP_MUL:                        res_sel = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  res_sel = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               res_sel = neg_if(acc[XLEN-1:0], neg_q);
         default:                       res_sel = neg_if(acc[2*XLEN-1:XLEN], neg_q);
      endcase
      if (special_q)
         res_sel = spec_res_q;
   end

   always_comb begin
      stall_o  = 1'b0;
      valid_o  = 1'b0;
      result_o = '0;
      case (state)
         IDLE: stall_o = start_i && !flush_i;
         BUSY: stall_o = 1'b1;
         DONE: begin
            valid_o  = !flush_i;
            result_o = flush_i ? '0 : res_sel;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed self-checking bench for execute_muldiv_unit.
module tb_execute_muldiv_unit;
   import rv_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start_i, flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] src_a_i, src_b_i, result_o;
   logic        stall_o, valid_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   execute_muldiv_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .src_a_i  (src_a_i),
      .src_b_i  (src_b_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .result_o (result_o),
      .valid_o  (valid_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept an op, scramble operands afterwards, measure latency/stall cycles and result.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit keep,
                         input string tag);
      int lat    = 0;
      int stalls = 1;
      bit got    = 1'b0;
      start_i  = 1'b1;
      funct3_i = f3;
      src_a_i  = a;
      src_b_i  = b;
      #1;
      chk({tag, "_stall_accept"}, {31'b0, stall_o}, 32'd1);
      while (!got && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         src_a_i  = $urandom;
         src_b_i  = $urandom;
         funct3_i = 3'($urandom);
         #1;
         if (valid_o) got = 1'b1;
         else if (stall_o) stalls++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_result"}, result_o, exp_res);
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
      chk({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
      if (!keep) begin
         start_i = 1'b0;
         step();
         chk({tag, "_idle_after"}, {30'b0, stall_o, valid_o}, 32'd0);
      end
   endtask

   initial begin
      int pulses;
      rst      = 1'b1;
      start_i  = 1'b0;
      flush_i  = 1'b0;
      funct3_i = 3'd0;
      src_a_i  = '0;
      src_b_i  = '0;
      repeat (3) step();
      chk("reset_outs", {stall_o, valid_o, result_o[29:0]}, 32'd0);
      chk("reset_result", result_o, 32'd0);
      rst = 1'b0;
      step();
      chk("idle_outs", {30'b0, stall_o, valid_o}, 32'd0);

      run_op(3'(OP_MUL),    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, "mul_7_m3");
      run_op(3'(OP_MULHU),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, "mulhu_ff");
      run_op(3'(OP_MULH),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0, "mulh_ff");
      run_op(3'(OP_MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, "mulhsu_ff");
      run_op(3'(OP_MULH),   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0, "mulh_min");
      run_op(3'(OP_MUL),    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33, 1'b0, "mul_min");
      run_op(3'(OP_DIV),    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0, "div_m7_2");
      run_op(3'(OP_REM),    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0, "rem_m7_2");
      run_op(3'(OP_DIVU),   32'd100,       32'd7,         32'd14,        33, 1'b0, "divu_100_7");
      run_op(3'(OP_REMU),   32'd100,       32'd7,         32'd2,         33, 1'b0, "remu_100_7");
      run_op(3'(OP_DIVU),   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0, "divu_nonovf");
      run_op(3'(OP_DIV),    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0, "div_by0");
      run_op(3'(OP_REMU),   32'd9,         32'd0,         32'd9,         1,  1'b0, "remu_by0");
      run_op(3'(OP_REM),    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0, "rem_ovf");
      run_op(3'(OP_DIV),    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0, "div_ovf");

      // Flush during iteration: no result, stall drops.
      start_i  = 1'b1;
      funct3_i = 3'(OP_MUL);
      src_a_i  = 32'd3;
      src_b_i  = 32'd5;
      step();
      repeat (9) step();
      flush_i = 1'b1;
      start_i = 1'b0;
      #1;
      chk("flush_valid_now", {31'b0, valid_o}, 32'd0);
      step();
      flush_i = 1'b0;
      #1;
      chk("flush_outs_next", {30'b0, stall_o, valid_o}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (valid_o || stall_o) pulses++;
      end
      chk("flush_no_result", 32'(pulses), 32'd0);

      // Reset during iteration.
      start_i  = 1'b1;
      funct3_i = 3'(OP_DIVU);
      src_a_i  = 32'd1000;
      src_b_i  = 32'd3;
      step();
      repeat (4) step();
      rst     = 1'b1;
      start_i = 1'b0;
      step();
      rst = 1'b0;
      #1;
      chk("rst_mid_outs", {30'b0, stall_o, valid_o}, 32'd0);
      chk("rst_mid_result", result_o, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (valid_o || stall_o) pulses++;
      end
      chk("rst_no_result", 32'(pulses), 32'd0);

      // Back-to-back: start stays high; the next op is presented in the DONE cycle.
      run_op(3'(OP_MUL), 32'd6, 32'd7, 32'd42, 33, 1'b1, "b2b_mul");
      funct3_i = 3'(OP_DIVU);
      src_a_i  = 32'd100;
      src_b_i  = 32'd7;
      step();
      run_op(3'(OP_DIVU), 32'd100, 32'd7, 32'd14, 33, 1'b0, "b2b_divu");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
